ipu_array_divider_pipe: RTL and testbench



---
 rtl/ipu_array_divider_pkg.sv | 36 +++
 rtl/ipu_array_divider_row.sv | 21 ++
 rtl/ipu_array_divider_pipe.sv | 117 +++++++++++
 tb/tb_ipu_array_divider_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipu_array_divider_pkg.sv
// Shared widths, record types and the restoring-division step for the IPU array divider.
// The pipeline top declares its own stage record with its actual parameter widths.
package ipu_array_divider_pkg;

    localparam int IPU_DIV_A_WIDTH = 8;
    localparam int IPU_DIV_B_WIDTH = 8;

    // Per-stage contents: divisor, partial remainder, and the remaining dividend bits
    // merged with the quotient bits produced so far.
    typedef struct packed {
        logic                       valid;
        logic [IPU_DIV_B_WIDTH-1:0] divisor;
        logic [IPU_DIV_B_WIDTH-1:0] rem;
        logic [IPU_DIV_A_WIDTH-1:0] dq;
    } div_stage_t;

    typedef struct packed {
        logic [IPU_DIV_A_WIDTH-1:0] q;
        logic [IPU_DIV_B_WIDTH-1:0] r;
    } div_result_t;

    // Returns {new_rem, qbit}.
    function automatic logic [IPU_DIV_B_WIDTH:0] div_step(
        input logic [IPU_DIV_B_WIDTH-1:0] rem,
        input logic                       dbit,
        input logic [IPU_DIV_B_WIDTH-1:0] b
    );
        logic [IPU_DIV_B_WIDTH:0] shifted;
        shifted = {rem, dbit};
        if (shifted >= {1'b0, b}) begin
            return {shifted[IPU_DIV_B_WIDTH-1:0] - b, 1'b1};
        end
        return {shifted[IPU_DIV_B_WIDTH-1:0], 1'b0};
    endfunction

endpackage

// File: rtl/ipu_array_divider_row.sv
// One combinational restoring-division row: shift in a dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module ipu_array_divider_row #(
    parameter int B_WIDTH = 8
) (
    input  logic [B_WIDTH-1:0] rem_i,
    input  logic               dbit_i,
    input  logic [B_WIDTH-1:0] b_i,
    output logic [B_WIDTH-1:0] rem_o,
    output logic               qbit_o
);

    logic [B_WIDTH:0] shifted;

    assign shifted = {rem_i, dbit_i};
    assign qbit_o  = (shifted >= {1'b0, b_i});

    // When the subtraction happens the result is below b, so the carry-out bit can be dropped.
    assign rem_o = qbit_o ? (shifted[B_WIDTH-1:0] - b_i) : shifted[B_WIDTH-1:0];

endmodule

// File: rtl/ipu_array_divider_pipe.sv
// Pipelined unsigned restoring divider: one row and one register stage per quotient bit,
// valid/ready on both sides with per-stage ready so bubbles collapse under backpressure.
module ipu_array_divider_pipe
    import ipu_array_divider_pkg::*;
#(
    parameter int A_WIDTH = IPU_DIV_A_WIDTH,
    parameter int B_WIDTH = IPU_DIV_B_WIDTH
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH-1:0] q,
    output logic [B_WIDTH-1:0] r
);

    // The last stage never passes its divisor on, so only the first A_WIDTH-1 stages keep one.
    localparam int DVS_N = (A_WIDTH > 1) ? A_WIDTH - 1 : 1;

    typedef struct packed {
        logic               valid;
        logic [B_WIDTH-1:0] rem;
        logic [A_WIDTH-1:0] dq;
    } stage_t;

    stage_t             stage_q [A_WIDTH];
    stage_t             stage_d [A_WIDTH];
    logic [B_WIDTH-1:0] dvs_q   [DVS_N];
    logic [A_WIDTH:0]   ready;

    logic [B_WIDTH-1:0] row_rem_in  [A_WIDTH];
    logic [A_WIDTH-1:0] row_dq_in   [A_WIDTH];
    logic [B_WIDTH-1:0] row_b       [A_WIDTH];
    logic [B_WIDTH-1:0] row_rem_out [A_WIDTH];
    logic [A_WIDTH-1:0] row_valid_in;
    logic [A_WIDTH-1:0] row_qbit;

    always_comb begin
        ready[A_WIDTH] = out_ready;
        for (int k = A_WIDTH - 1; k >= 0; k--) begin
            ready[k] = ~stage_q[k].valid | ready[k+1];
        end
    end

    assign in_ready = ready[0] & ~clr;

    // Stage 0 works straight from the inputs; later stages from their predecessor's registers.
    always_comb begin
        row_rem_in[0]   = '0;
        row_dq_in[0]    = a;
        row_b[0]        = b;
        row_valid_in[0] = in_valid;
        for (int k = 1; k < A_WIDTH; k++) begin
            row_rem_in[k]   = stage_q[k-1].rem;
            row_dq_in[k]    = stage_q[k-1].dq;
            row_b[k]        = dvs_q[k-1];
            row_valid_in[k] = stage_q[k-1].valid;
        end
    end

    for (genvar k = 0; k < A_WIDTH; k++) begin : g_row
        ipu_array_divider_row #(
            .B_WIDTH (B_WIDTH)
        ) u_row (
            .rem_i  (row_rem_in[k]),
            .dbit_i (row_dq_in[k][A_WIDTH-1]),
            .b_i    (row_b[k]),
            .rem_o  (row_rem_out[k]),
            .qbit_o (row_qbit[k])
        );
    end

    // Consumed dividend MSB falls off the top while the new quotient bit enters at the bottom.
    always_comb begin
        for (int k = 0; k < A_WIDTH; k++) begin
            stage_d[k].valid = row_valid_in[k];
            stage_d[k].rem   = row_rem_out[k];
            stage_d[k].dq    = A_WIDTH'({row_dq_in[k], row_qbit[k]});
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int k = 0; k < A_WIDTH; k++) begin
                stage_q[k] <= '0;
            end
            for (int j = 0; j < DVS_N; j++) begin
                dvs_q[j] <= '0;
            end
        end else if (clr) begin
            for (int k = 0; k < A_WIDTH; k++) begin
                stage_q[k].valid <= 1'b0;
            end
        end else begin
            for (int k = 0; k < A_WIDTH; k++) begin
                if (ready[k]) begin
                    stage_q[k] <= stage_d[k];
                end
            end
            for (int k = 0; k < A_WIDTH - 1; k++) begin
                if (ready[k]) begin
                    dvs_q[k] <= row_b[k];
                end
            end
        end
    end

    assign out_valid = stage_q[A_WIDTH-1].valid;
    assign q         = stage_q[A_WIDTH-1].dq;
    assign r         = stage_q[A_WIDTH-1].rem;

endmodule

// File: tb/tb_ipu_array_divider_pipe.sv
// Scoreboard bench for ipu_array_divider_pipe: streaming, backpressure, flush, divide by zero,
// async reset mid-stream and an exhaustive 8x8 sweep cross-checked against a row chain.
module tb_ipu_array_divider_pipe;
    import ipu_array_divider_pkg::*;

    localparam int AW = 8;
    localparam int BW = 8;

    logic          clk;
    logic          nreset;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] q;
    logic [BW-1:0] r;

    ipu_array_divider_pipe #(
        .A_WIDTH (AW),
        .B_WIDTH (BW)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r)
    );

    logic [BW-1:0] chainRem [AW+1];
    logic [AW-1:0] chainQ;

    assign chainRem[0] = '0;
    for (genvar k = 0; k < AW; k++) begin : g_chain
        ipu_array_divider_row #(
            .B_WIDTH (BW)
        ) u_row (
            .rem_i  (chainRem[k]),
            .dbit_i (a[AW-1-k]),
            .b_i    (b),
            .rem_o  (chainRem[k+1]),
            .qbit_o (chainQ[AW-1-k])
        );
    end

    typedef struct {
        div_result_t res;
        int          cycle;
    } sbEntry_t;

    sbEntry_t    sbq[$];
    int          assertionCount = 0;
    int          failCount      = 0;
    int          cycleCount     = 0;
    bit          latencyCheck   = 0;
    bit          chainCheck     = 0;
    bit          stallPrev      = 0;
    bit          flushPrev      = 0;
    logic [AW-1:0] heldQ;
    logic [BW-1:0] heldR;
    sbEntry_t    monEnt;
    div_result_t monExp;
    logic        monExpReady;

    logic [7:0] streamA [11] = '{8'd15, 8'd10, 8'd2, 8'd12, 8'd12, 8'd255, 8'd150, 8'd16, 8'd50, 8'd21, 8'd27};
    logic [7:0] streamB [11] = '{8'd1, 8'd5, 8'd2, 8'd3, 8'd4, 8'd15, 8'd10, 8'd128, 8'd40, 8'd3, 8'd9};
    logic [7:0] resetA  [5]  = '{8'd200, 8'd99, 8'd77, 8'd250, 8'd13};
    logic [7:0] resetB  [5]  = '{8'd3, 8'd9, 8'd5, 8'd250, 8'd2};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCount++;

    function automatic div_result_t modelDiv(input logic [7:0] av, input logic [7:0] bv);
        div_result_t res;
        if (bv == 8'd0) begin
            res.q = 8'hFF;
            res.r = av;
        end else begin
            res.q = av / bv;
            res.r = av % bv;
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertionCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycleCount);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge; report whether a/b was taken.
    task automatic applyStimulus(input logic v, input logic [7:0] av, input logic [7:0] bv,
                                 input logic ordy, input logic clrv, output logic accepted);
        in_valid  = v;
        a         = av;
        b         = bv;
        out_ready = ordy;
        clr       = clrv;
        @(negedge clk);
        accepted = v & in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic sendOp(input logic [7:0] av, input logic [7:0] bv);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            applyStimulus(1'b1, av, bv, 1'b1, 1'b0, acc);
            n++;
        end
        if (!acc) checkOutput("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain(input int maxCycles);
        logic acc;
        int   n;
        n = 0;
        while (sbq.size() != 0 && n < maxCycles) begin
            applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, acc);
            n++;
        end
        if (sbq.size() != 0) checkOutput("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    // Scoreboard monitor: sampled on the falling edge, mid-way between driver updates.
    always @(negedge clk) begin
        if (!nreset) begin
            sbq.delete();
            stallPrev = 1'b0;
            flushPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_q", 32'(q), 32'(heldQ));
                checkOutput("stall_r", 32'(r), 32'(heldR));
            end
            if (flushPrev) checkOutput("flush_empty", 32'(out_valid), 32'd0);
            monExpReady = !clr && (sbq.size() < AW || out_ready);
            checkOutput("in_ready", 32'(in_ready), 32'(monExpReady));
            if (chainCheck && in_valid) begin
                monExp = modelDiv(a, b);
                checkOutput("comb_chain", 32'({chainQ, chainRem[AW]}), 32'(monExp));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_out", 32'd1, 32'd0);
                end else begin
                    monEnt = sbq.pop_front();
                    checkOutput("result_q", 32'(q), 32'(monEnt.res.q));
                    checkOutput("result_r", 32'(r), 32'(monEnt.res.r));
                    if (latencyCheck) checkOutput("latency", 32'(cycleCount - monEnt.cycle), 32'(AW));
                end
            end
            if (in_valid && in_ready) begin
                monEnt.res   = modelDiv(a, b);
                monEnt.cycle = cycleCount;
                sbq.push_back(monEnt);
            end
            if (clr) sbq.delete();
            stallPrev = out_valid && !out_ready && !clr;
            flushPrev = clr;
            heldQ     = q;
            heldR     = r;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc;
        int   idx;
        int   c;
        bit   ordy;
        bit   v;

        nreset    = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_q", 32'(q), 32'd0);
        checkOutput("reset_r", 32'(r), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        #2 nreset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] streaming with out_ready high");
        latencyCheck = 1'b1;
        for (int i = 0; i < 11; i++) sendOp(streamA[i], streamB[i]);
        drain(40);

        $display("[TB] backpressure and input gaps");
        latencyCheck = 1'b0;
        idx = 0;
        c   = 0;
        while (idx < 24 && c < 300) begin
            ordy = !(c inside {5, 7, 8, 10} || (c >= 14 && c <= 25));
            v    = !(c inside {10, 11});
            applyStimulus(v, 8'(idx * 37 + 5), 8'(idx * 13 + 1), ordy, 1'b0, acc);
            if (acc) idx++;
            c++;
        end
        if (idx < 24) checkOutput("backpressure_timeout", 32'(idx), 32'd24);
        drain(40);

        $display("[TB] flush in the middle of a stream");
        latencyCheck = 1'b1;
        for (int cc = 0; cc < 40; cc++) begin
            applyStimulus(1'b1, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b1, (cc == 32), acc);
        end
        sendOp(8'd100, 8'd7);
        drain(40);

        $display("[TB] divide by zero");
        sendOp(8'd200, 8'd0);
        sendOp(8'd0, 8'd0);
        drain(40);

        $display("[TB] async reset with work in flight");
        latencyCheck = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, resetA[i], resetB[i], 1'b0, 1'b0, acc);
            if (!acc) checkOutput("reset_fill_accept", 32'(acc), 32'd1);
        end
        repeat (8) applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, acc);
        checkOutput("pre_reset_out_valid", 32'(out_valid), 32'd1);
        #2 nreset = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_q", 32'(q), 32'd0);
        checkOutput("midreset_r", 32'(r), 32'd0);
        @(negedge clk);
        #2 nreset = 1'b1;
        #1;
        checkOutput("postreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("postreset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        latencyCheck = 1'b1;
        sendOp(8'd255, 8'd1);
        drain(40);

        $display("[TB] exhaustive sweep with row-chain cross-check");
        chainCheck = 1'b1;
        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 1; bi < 256; bi++) begin
                sendOp(8'(ai), 8'(bi));
            end
        end
        drain(40);
        chainCheck = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
        $finish;
    end

endmodule
